// File: rtl/multi_flash_led_if.sv
// Control/status bundle between the LED pattern engine and its mode source.
// The mode source loads a pattern; the engine drives the LED pins and step pulse.
interface multi_flash_led_if #(
    parameter int N_LED = 4
);
    logic [1:0]       mode;
    logic             mode_vld;
    logic [N_LED-1:0] led;
    logic             step;

    modport master (
        output mode,
        output mode_vld,
        input  led,
        input  step
    );

    modport slave (
        input  mode,
        input  mode_vld,
        output led,
        output step
    );
endinterface

// File: rtl/multi_flash_led.sv
// Multi-LED flasher: a shared prescaler steps an OFF/BLINK/CHASE/BREATHE pattern.
// A mode load restarts the pattern and takes priority over a coincident step.
module multi_flash_led #(
    parameter int N_LED    = 4,
    parameter int DIV_CNT  = 25_000_000,
    parameter int PWM_BITS = 8
) (
    input logic             sclk,
    input logic             rst,
    multi_flash_led_if.slave bus
);
    localparam int CNT_W = (DIV_CNT > 1) ? $clog2(DIV_CNT) : 1;

    localparam logic [1:0] MODE_OFF     = 2'd0;
    localparam logic [1:0] MODE_BLINK   = 2'd1;
    localparam logic [1:0] MODE_CHASE   = 2'd2;
    localparam logic [1:0] MODE_BREATHE = 2'd3;

    localparam logic [CNT_W-1:0]    PRESC_MAX = CNT_W'(DIV_CNT - 1);
    localparam logic [CNT_W-1:0]    PRESC_ONE = CNT_W'(1);
    localparam logic [PWM_BITS-1:0] DUTY_MAX  = {PWM_BITS{1'b1}};
    localparam logic [PWM_BITS-1:0] DUTY_ONE  = PWM_BITS'(1);

    logic [1:0]          cur_mode;
    logic [CNT_W-1:0]    presc;
    logic [PWM_BITS-1:0] pwm;
    logic [PWM_BITS-1:0] duty;
    logic                dir_up;
    logic [N_LED-1:0]    led_r;
    logic                step_r;
    logic                wrap;

    assign wrap     = (presc == PRESC_MAX);
    assign bus.led  = led_r;
    assign bus.step = step_r;

    always_ff @(posedge sclk) begin
        if (rst) begin
            cur_mode <= MODE_OFF;
            presc    <= '0;
            pwm      <= '0;
            duty     <= '0;
            dir_up   <= 1'b1;
            led_r    <= '0;
            step_r   <= 1'b0;
        end else if (bus.mode_vld) begin
            cur_mode <= bus.mode;
            presc    <= '0;
            pwm      <= '0;
            duty     <= '0;
            dir_up   <= 1'b1;
            step_r   <= 1'b0;
            led_r    <= (bus.mode == MODE_CHASE) ? N_LED'(1) : '0;
        end else begin
            step_r <= wrap;
            presc  <= wrap ? '0 : presc + PRESC_ONE;
            pwm    <= pwm + DUTY_ONE;
            case (cur_mode)
                MODE_BLINK: begin
                    if (wrap) led_r <= ~led_r;
                end
                MODE_CHASE: begin
                    // Shifting right by N_LED-1 brings the top bit back to bit0 (and keeps N_LED=1 lit).
                    if (wrap) led_r <= (led_r << 1) | (led_r >> (N_LED - 1));
                end
                MODE_BREATHE: begin
                    led_r <= {N_LED{pwm < duty}};
                    if (wrap) begin
                        if (dir_up) begin
                            if (duty == DUTY_MAX) begin
                                dir_up <= 1'b0;
                                duty   <= DUTY_MAX - DUTY_ONE;
                            end else begin
                                duty <= duty + DUTY_ONE;
                            end
                        end else begin
                            if (duty == '0) begin
                                dir_up <= 1'b1;
                                duty   <= DUTY_ONE;
                            end else begin
                                duty <= duty - DUTY_ONE;
                            end
                        end
                    end
                end
                default: begin
                    led_r <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_multi_flash_led.sv
// Directed bench for multi_flash_led with N_LED=4, DIV_CNT=4, PWM_BITS=3.
// A vector table covers reset, BLINK, CHASE and restart; BREATHE and reset corners are sequences.
module tb_multi_flash_led;
    localparam int N_LED    = 4;
    localparam int DIV_CNT  = 4;
    localparam int PWM_BITS = 3;

    logic sclk = 1'b0;
    logic rst;

    multi_flash_led_if #(.N_LED(N_LED)) bus ();

    multi_flash_led #(
        .N_LED   (N_LED),
        .DIV_CNT (DIV_CNT),
        .PWM_BITS(PWM_BITS)
    ) dut (
        .sclk(sclk),
        .rst (rst),
        .bus (bus)
    );

    always #5 sclk = ~sclk;

    typedef struct {
        logic       r;
        logic       v;
        logic [1:0] m;
        logic [3:0] led;
        logic       st;
    } vec_t;

    vec_t vecs[$];
    int checks   = 0;
    int failures = 0;

    task automatic push(input logic r, input logic v, input logic [1:0] m,
                        input logic [3:0] l, input logic s);
        vec_t e;
        e.r = r; e.v = v; e.m = m; e.led = l; e.st = s;
        vecs.push_back(e);
    endtask

    // Idle cycles without a step; mode is deliberately non-zero to show it is ignored.
    task automatic hold(input int n, input logic [3:0] l);
        for (int i = 0; i < n; i++) push(1'b0, 1'b0, 2'd3, l, 1'b0);
    endtask

    task automatic applyStimulus(input logic r, input logic v, input logic [1:0] m);
        rst          = r;
        bus.mode_vld = v;
        bus.mode     = m;
        @(posedge sclk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [3:0] el, input logic es);
        checks++;
        if (bus.led !== el || bus.step !== es) begin
            failures++;
            $display("[TB] FAIL %s: led=%b step=%b, expected led=%b step=%b",
                     name, bus.led, bus.step, el, es);
        end
    endtask

    function automatic int triDuty(input int j);
        int p;
        p = j % 14;
        return (p <= 7) ? p : 14 - p;
    endfunction

    initial begin
        logic [3:0] el;
        logic       es;

        rst          = 1'b1;
        bus.mode_vld = 1'b0;
        bus.mode     = 2'd0;

        // Reset, then free-running prescaler in OFF.
        push(1, 0, 0, 4'h0, 0); push(1, 0, 0, 4'h0, 0); push(1, 0, 0, 4'h0, 0);
        hold(3, 4'h0); push(0, 0, 0, 4'h0, 1);
        hold(3, 4'h0); push(0, 0, 0, 4'h0, 1);
        // BLINK load and two steps.
        push(0, 1, 1, 4'h0, 0);
        hold(3, 4'h0); push(0, 0, 0, 4'hF, 1);
        hold(3, 4'hF); push(0, 0, 0, 4'h0, 1);
        // CHASE load, full wrap and on into the next lap.
        push(0, 1, 2, 4'h1, 0);
        hold(3, 4'h1); push(0, 0, 0, 4'h2, 1);
        hold(3, 4'h2); push(0, 0, 0, 4'h4, 1);
        hold(3, 4'h4); push(0, 0, 0, 4'h8, 1);
        hold(3, 4'h8); push(0, 0, 0, 4'h1, 1);
        hold(3, 4'h1); push(0, 0, 0, 4'h2, 1);
        hold(3, 4'h2); push(0, 0, 0, 4'h4, 1);
        hold(3, 4'h4);
        // Reload CHASE on a wrap edge: load wins over the step.
        push(0, 1, 2, 4'h1, 0);
        hold(3, 4'h1); push(0, 0, 0, 4'h2, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].r, vecs[i].v, vecs[i].m);
            checkOutput($sformatf("vec%0d", i), vecs[i].led, vecs[i].st);
        end

        // BREATHE: duty follows the triangle 0..7..0..; led reflects previous pwm/duty.
        applyStimulus(0, 1, 3);
        checkOutput("breathe_load", 4'h0, 1'b0);
        for (int n = 1; n <= 64; n++) begin
            applyStimulus(0, 0, 0);
            el = (((n - 1) % 8) < triDuty((n - 1) / 4)) ? 4'hF : 4'h0;
            es = ((n % 4) == 0);
            checkOutput($sformatf("breathe_e%0d", n), el, es);
        end

        // Reset while BREATHE duty is 5 and the prescaler is mid-count.
        applyStimulus(0, 1, 3);
        for (int n = 1; n <= 22; n++) applyStimulus(0, 0, 0);
        applyStimulus(1, 0, 0);
        checkOutput("reset_mid_breathe", 4'h0, 1'b0);
        for (int n = 1; n <= 8; n++) begin
            applyStimulus(0, 0, 0);
            checkOutput($sformatf("after_reset_e%0d", n), 4'h0, (n % 4) == 0);
        end

        // Reset and a CHASE load on the same edge: reset wins, so led stays dark.
        applyStimulus(1, 1, 2);
        checkOutput("rst_vs_load", 4'h0, 1'b0);
        for (int n = 1; n <= 8; n++) begin
            applyStimulus(0, 0, 0);
            checkOutput($sformatf("rst_wins_e%0d", n), 4'h0, (n % 4) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
